// File: rtl/xvec_pkg.sv
// Shared definitions for the x-vector deserializer
// and the logic blocks that consume its vector.
package xvec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int XVEC_N      = 3;
    localparam int XVEC_FCNT_W = 8;

endpackage

// File: rtl/xvec_deserializer_if.sv
// Serial-in / parallel-out handshake bundle.
// master drives serial bits and consumes x; slave is the deserializer.
interface xvec_deserializer_if
    import xvec_pkg::*;
#(
    parameter int N = XVEC_N
) ();

    logic         sin_valid;
    logic         sin_data;
    logic         frame_start;
    logic         sin_ready;
    logic [N-1:0] x_out;
    logic         x_valid;
    logic         x_ready;

    modport master (
        output sin_valid, sin_data, frame_start, x_ready,
        input  sin_ready, x_out, x_valid
    );

    modport slave (
        input  sin_valid, sin_data, frame_start, x_ready,
        output sin_ready, x_out, x_valid
    );

endinterface

// File: rtl/xvec_deserializer.sv
// LSB-first framed serial-to-parallel converter with
// valid/ready on both sides, sticky error flags and a frame counter.
module xvec_deserializer
    import xvec_pkg::*;
#(
    parameter int N      = XVEC_N,
    parameter int FCNT_W = XVEC_FCNT_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    xvec_deserializer_if.slave bus,
    output logic              err_abort,
    output logic              err_stray,
    input  logic              clear_err,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int CNT_W = $clog2(N + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N-1:0]      x_q, x_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              acc, hof, last;
    logic              load0, shift_in;
    logic              abort_set, stray_set;

    assign acc  = bus.sin_valid & bus.sin_ready;
    assign hof  = bus.x_valid & bus.x_ready;
    assign last = (cnt_q == CNT_W'(N - 1));

    assign bus.x_out = x_q;
    assign frame_cnt = fcnt_q;

    // FSM state register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // FSM next state and datapath action decode
    always_comb begin
        state_d   = state_q;
        load0     = 1'b0;
        shift_in  = 1'b0;
        abort_set = 1'b0;
        stray_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc && bus.frame_start) begin
                    load0   = 1'b1;
                    state_d = (N == 1) ? HOLD : SHIFT;
                end else if (acc) begin
                    stray_set = 1'b1;
                end
            end
            SHIFT: begin
                if (acc && bus.frame_start) begin
                    load0     = 1'b1;
                    abort_set = 1'b1;
                end else if (acc) begin
                    shift_in = 1'b1;
                    if (last) state_d = HOLD;
                end
            end
            HOLD: begin
                if (hof) begin
                    state_d = IDLE;
                    if (acc && bus.frame_start) begin
                        load0   = 1'b1;
                        state_d = (N == 1) ? HOLD : SHIFT;
                    end else if (acc) begin
                        stray_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready is gated by reset and by a held frame
    always_comb begin
        bus.x_valid   = (state_q == HOLD);
        bus.sin_ready = Resetn &
                        ((state_q != HOLD) | bus.x_ready);
    end

    // Next vector, bit index and frame count
    always_comb begin
        x_d    = x_q;
        cnt_d  = cnt_q;
        fcnt_d = fcnt_q;
        if (hof) fcnt_d = fcnt_q + FCNT_W'(1);
        if (load0) begin
            x_d[0] = bus.sin_data;
            cnt_d  = CNT_W'(1);
        end else if (shift_in) begin
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CNT_W'(i)) x_d[i] = bus.sin_data;
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Datapath registers; clear_err beats a same-cycle flag set
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            x_q       <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
            err_abort <= 1'b0;
            err_stray <= 1'b0;
        end else begin
            x_q    <= x_d;
            cnt_q  <= cnt_d;
            fcnt_q <= fcnt_d;
            if (clear_err) begin
                err_abort <= 1'b0;
                err_stray <= 1'b0;
            end else begin
                if (abort_set) err_abort <= 1'b1;
                if (stray_set) err_stray <= 1'b1;
            end
        end
    end

endmodule
